// File: rtl/scan_if.sv
// Bundle between scan_sequencer (master) and the matrix driver / frame-buffer datapath (slave).
// Optional macro SCAN_DIM_EN adds the dim[1:0] global brightness select.
interface scan_if #(
    parameter int COLS   = 32,
    parameter int ROWS   = 16,
    parameter int CDEPTH = 4
);
    localparam int CW = $clog2(COLS);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PW = (CDEPTH > 1) ? $clog2(CDEPTH) : 1;

    logic          en;
    logic          swap_req;
    logic          swap_ack;
    logic          buf_sel;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [PW-1:0] plane;
    logic          mclk;
    logic          latch;
    logic          oe_n;
    logic [RW-1:0] rsel;
    logic          frame_done;
`ifdef SCAN_DIM_EN
    logic [1:0]    dim;
`endif

    modport master (
`ifdef SCAN_DIM_EN
        input  dim,
`endif
        input  en, swap_req,
        output swap_ack, buf_sel, col, row, plane, mclk, latch, oe_n, rsel, frame_done
    );

    modport slave (
`ifdef SCAN_DIM_EN
        output dim,
`endif
        output en, swap_req,
        input  swap_ack, buf_sel, col, row, plane, mclk, latch, oe_n, rsel, frame_done
    );
endinterface

// File: rtl/scan_sequencer.sv
// LED matrix scan timing master: SHIFT -> BLANK -> LATCH -> DISPLAY with binary-coded modulation.
// Optional macro SCAN_DIM_EN: oe_n low only for the first (BASE_T<<plane)>>dim DISPLAY cycles.
module scan_sequencer #(
    parameter int COLS      = 32,
    parameter int ROWS      = 16,
    parameter int CDEPTH    = 4,
    parameter int MCLK_DIV  = 4,
    parameter int BASE_T    = 8,
    parameter int BLANK_CYC = 2
) (
    input  logic   clk,
    input  logic   reset,
    scan_if.master bus
);
    localparam int CW       = $clog2(COLS);
    localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PW       = (CDEPTH > 1) ? $clog2(CDEPTH) : 1;
    localparam int DISP_MAX = BASE_T << (CDEPTH - 1);
    localparam int TMAX_A   = (DISP_MAX > MCLK_DIV) ? DISP_MAX : MCLK_DIV;
    localparam int TMAX     = (TMAX_A > BLANK_CYC) ? TMAX_A : BLANK_CYC;
    localparam int TW       = $clog2(TMAX) + 1;

    localparam logic [TW-1:0] MDIV_LAST  = TW'(MCLK_DIV - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [PW-1:0] PLANE_LAST = PW'(CDEPTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_BLANK, S_LATCH, S_DISPLAY} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [PW-1:0] plane_q, plane_d;
    logic [RW-1:0] rsel_q, rsel_d;
    logic          mclk_q, mclk_d;
    logic          latch_q, latch_d;
    logic          oe_n_q, oe_n_d;
    logic          buf_sel_q, buf_sel_d;
    logic          frame_done_q, frame_done_d;

    logic [TW-1:0] disp_len, disp_last, cnt_inc;
    logic          last_slot, swap_take;

    assign disp_len  = TW'(BASE_T) << plane_q;
    assign disp_last = disp_len - TW'(1);
    assign cnt_inc   = cnt_q + TW'(1);
    assign last_slot = (row_q == ROW_LAST) && (plane_q == PLANE_LAST);
    // Swap is granted in the frame's last cycle so the new front buffer starts at row 0.
    assign swap_take = frame_done_q & bus.swap_req;

`ifdef SCAN_DIM_EN
    logic [1:0]    dim_q, dim_d;
    logic [TW-1:0] on_len_latch, on_len;
    assign on_len_latch = disp_len >> bus.dim;
    assign on_len       = disp_len >> dim_q;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        col_d        = col_q;
        row_d        = row_q;
        plane_d      = plane_q;
        rsel_d       = rsel_q;
        mclk_d       = 1'b0;
        latch_d      = 1'b0;
        oe_n_d       = 1'b1;
        frame_done_d = 1'b0;
        buf_sel_d    = buf_sel_q ^ swap_take;
`ifdef SCAN_DIM_EN
        dim_d        = dim_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.en) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                mclk_d = mclk_q;
                if (cnt_q == MDIV_LAST) begin
                    cnt_d  = '0;
                    mclk_d = ~mclk_q;
                    if (mclk_q) begin
                        if (col_q == COL_LAST) begin
                            col_d   = '0;
                            state_d = S_BLANK;
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d   = '0;
                    state_d = S_LATCH;
                    latch_d = 1'b1;
                    rsel_d  = row_q;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_LATCH: begin
                cnt_d        = '0;
                state_d      = S_DISPLAY;
                frame_done_d = last_slot && (disp_len == TW'(1));
`ifdef SCAN_DIM_EN
                dim_d        = bus.dim;
                oe_n_d       = (on_len_latch == '0);
`else
                oe_n_d       = 1'b0;
`endif
            end
            S_DISPLAY: begin
                if (cnt_q == disp_last) begin
                    cnt_d = '0;
                    if (plane_q == PLANE_LAST) begin
                        plane_d = '0;
                        row_d   = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
                    end else begin
                        plane_d = plane_q + PW'(1);
                    end
                    state_d = (frame_done_q && !bus.en) ? S_IDLE : S_SHIFT;
                end else begin
                    cnt_d        = cnt_inc;
                    frame_done_d = last_slot && (cnt_inc == disp_last);
`ifdef SCAN_DIM_EN
                    oe_n_d       = !(cnt_inc < on_len);
`else
                    oe_n_d       = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
            plane_q      <= '0;
            rsel_q       <= '0;
            mclk_q       <= 1'b0;
            latch_q      <= 1'b0;
            oe_n_q       <= 1'b1;
            buf_sel_q    <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef SCAN_DIM_EN
            dim_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            col_q        <= col_d;
            row_q        <= row_d;
            plane_q      <= plane_d;
            rsel_q       <= rsel_d;
            mclk_q       <= mclk_d;
            latch_q      <= latch_d;
            oe_n_q       <= oe_n_d;
            buf_sel_q    <= buf_sel_d;
            frame_done_q <= frame_done_d;
`ifdef SCAN_DIM_EN
            dim_q        <= dim_d;
`endif
        end
    end

    assign bus.swap_ack   = swap_take;
    assign bus.buf_sel    = buf_sel_q;
    assign bus.col        = col_q;
    assign bus.row        = row_q;
    assign bus.plane      = plane_q;
    assign bus.mclk       = mclk_q;
    assign bus.latch      = latch_q;
    assign bus.oe_n       = oe_n_q;
    assign bus.rsel       = rsel_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer with a small 4x2x2 configuration (52 cycles per frame).
// Build with SCAN_DIM_EN defined to also exercise the dimming option.
module tb_scan_sequencer;
    localparam int COLS = 4, ROWS = 2, CDEPTH = 2, MCLK_DIV = 1, BASE_T = 2, BLANK_CYC = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    scan_if #(.COLS(COLS), .ROWS(ROWS), .CDEPTH(CDEPTH)) bus ();

    scan_sequencer #(
        .COLS(COLS), .ROWS(ROWS), .CDEPTH(CDEPTH),
        .MCLK_DIV(MCLK_DIV), .BASE_T(BASE_T), .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic       mclk;
        logic       latch;
        logic       oe_n;
        logic       frame_done;
        logic       swap_ack;
        logic       buf_sel;
        logic [1:0] col;
        logic       row;
        logic       plane;
        logic       rsel;
    } obs_t;

    typedef struct packed {
        int   cyc;
        logic en;
        logic swap_req;
        obs_t exp;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];
    int checks   = 0;
    int failures = 0;

    function automatic obs_t mk_obs(input logic m, l, o, f, a, b, input logic [1:0] c,
                                    input logic r, p, s);
        obs_t x;
        x.mclk = m; x.latch = l; x.oe_n = o; x.frame_done = f; x.swap_ack = a;
        x.buf_sel = b; x.col = c; x.row = r; x.plane = p; x.rsel = s;
        return x;
    endfunction

    function automatic vec_t mk(input int cy, input logic e, sr, input obs_t x);
        vec_t v;
        v.cyc = cy; v.en = e; v.swap_req = sr; v.exp = x;
        return v;
    endfunction

    function automatic obs_t sample();
        return mk_obs(bus.mclk, bus.latch, bus.oe_n, bus.frame_done, bus.swap_ack,
                      bus.buf_sel, bus.col, bus.row, bus.plane, bus.rsel);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset, then release with en set; returns one tick into the first SHIFT cycle.
    task automatic start_run(input logic en_v, input logic [1:0] dim_v);
        reset = 1'b1;
        bus.en = en_v;
        bus.swap_req = 1'b0;
`ifdef SCAN_DIM_EN
        bus.dim = dim_v;
`else
        if (dim_v != 2'd0) $display("note: dim ignored in this build");
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic run_vectors(input string tag);
        int   vi = 0;
        int   fd_cnt = 0, ack_cnt = 0, oe_low0 = 0, latch0 = 0, rsel_bad = 0;
        logic prev_rsel = 1'b0;
        obs_t cur;
        for (int k = 0; k <= 156; k++) begin
            if (k > 0) tick();
            if (vi < NV && vecs[vi].cyc == k) begin
                bus.en       = vecs[vi].en;
                bus.swap_req = vecs[vi].swap_req;
            end
            #1;
            cur = sample();
            if (vi < NV && vecs[vi].cyc == k) begin
                check($sformatf("%s_cyc%0d", tag, k), 32'(cur), 32'(vecs[vi].exp));
                vi++;
            end
            if (cur.frame_done) fd_cnt++;
            if (cur.swap_ack) ack_cnt++;
            if (k < 52 && !cur.oe_n) oe_low0++;
            if (k < 52 && cur.latch) latch0++;
            if (k > 0 && cur.rsel != prev_rsel && !cur.oe_n) rsel_bad++;
            prev_rsel = cur.rsel;
        end
        bus.swap_req = 1'b0;
        check({tag, "_frame_done_pulses"}, 32'(fd_cnt), 32'd3);
        check({tag, "_swap_ack_pulses"}, 32'(ack_cnt), 32'd2);
        check({tag, "_oe_low_cycles_f0"}, 32'(oe_low0), 32'd12);
        check({tag, "_latch_pulses_f0"}, 32'(latch0), 32'd4);
        check({tag, "_rsel_change_while_lit"}, 32'(rsel_bad), 32'd0);
    endtask

    initial begin
        vecs[0]  = mk(0,   1, 0, mk_obs(0,0,1,0,0,0,2'd0,0,0,0));
        vecs[1]  = mk(1,   1, 0, mk_obs(1,0,1,0,0,0,2'd0,0,0,0));
        vecs[2]  = mk(2,   1, 0, mk_obs(0,0,1,0,0,0,2'd1,0,0,0));
        vecs[3]  = mk(7,   1, 0, mk_obs(1,0,1,0,0,0,2'd3,0,0,0));
        vecs[4]  = mk(8,   1, 0, mk_obs(0,0,1,0,0,0,2'd0,0,0,0));
        vecs[5]  = mk(9,   1, 0, mk_obs(0,1,1,0,0,0,2'd0,0,0,0));
        vecs[6]  = mk(10,  1, 1, mk_obs(0,0,0,0,0,0,2'd0,0,0,0));
        vecs[7]  = mk(11,  1, 1, mk_obs(0,0,0,0,0,0,2'd0,0,0,0));
        vecs[8]  = mk(12,  1, 1, mk_obs(0,0,1,0,0,0,2'd0,0,1,0));
        vecs[9]  = mk(21,  1, 1, mk_obs(0,1,1,0,0,0,2'd0,0,1,0));
        vecs[10] = mk(22,  1, 1, mk_obs(0,0,0,0,0,0,2'd0,0,1,0));
        vecs[11] = mk(25,  1, 1, mk_obs(0,0,0,0,0,0,2'd0,0,1,0));
        vecs[12] = mk(26,  1, 1, mk_obs(0,0,1,0,0,0,2'd0,1,0,0));
        vecs[13] = mk(34,  1, 1, mk_obs(0,0,1,0,0,0,2'd0,1,0,0));
        vecs[14] = mk(35,  1, 1, mk_obs(0,1,1,0,0,0,2'd0,1,0,1));
        vecs[15] = mk(36,  1, 1, mk_obs(0,0,0,0,0,0,2'd0,1,0,1));
        vecs[16] = mk(51,  1, 1, mk_obs(0,0,0,1,1,0,2'd0,1,1,1));
        vecs[17] = mk(52,  1, 1, mk_obs(0,0,1,0,0,1,2'd0,0,0,1));
        vecs[18] = mk(61,  1, 1, mk_obs(0,1,1,0,0,1,2'd0,0,0,0));
        vecs[19] = mk(103, 1, 1, mk_obs(0,0,0,1,1,1,2'd0,1,1,1));
        vecs[20] = mk(104, 1, 0, mk_obs(0,0,1,0,0,0,2'd0,0,0,1));
        vecs[21] = mk(155, 1, 0, mk_obs(0,0,0,1,0,0,2'd0,1,1,1));

        reset = 1'b1;
        bus.en = 1'b0;
        bus.swap_req = 1'b0;
`ifdef SCAN_DIM_EN
        bus.dim = 2'd0;
`endif
        repeat (2) @(negedge clk);
        check("reset_state", 32'(sample()), 32'(mk_obs(0,0,1,0,0,0,2'd0,0,0,0)));

        // T1 + T2: two-plus frames, swap_req held from cycle 10 through the second ack.
        start_run(1'b1, 2'd0);
        run_vectors("t1");

        // T4: get into DISPLAY with buf_sel=1 and rsel=1, then pulse reset between edges.
        start_run(1'b1, 2'd0);
        for (int k = 0; k <= 88; k++) begin
            if (k > 0) tick();
            bus.swap_req = (k < 88);
        end
        #1;
        check("t4_pre_reset", 32'(sample()), 32'(mk_obs(0,0,0,0,0,1,2'd0,1,0,1)));
        #1 reset = 1'b1;
        #1;
        check("t4_async_reset", 32'(sample()), 32'(mk_obs(0,0,1,0,0,0,2'd0,0,0,0)));
        start_run(1'b1, 2'd0);
        run_vectors("t4");

        // T3: en dropped early; the frame still completes, then the sequencer idles.
        start_run(1'b1, 2'd0);
        for (int k = 0; k <= 60; k++) begin
            if (k > 0) tick();
            if (k == 5) bus.en = 1'b0;
            #1;
            if (k == 36) check("t3_display_r1", 32'(bus.oe_n), 32'd0);
            if (k == 51) check("t3_frame_done", 32'(bus.frame_done), 32'd1);
            if (k == 52) check("t3_idle_entry", 32'(sample()), 32'(mk_obs(0,0,1,0,0,0,2'd0,0,0,1)));
            if (k == 53) check("t3_idle_no_mclk", 32'(bus.mclk), 32'd0);
            if (k == 60) check("t3_idle_hold", 32'(sample()), 32'(mk_obs(0,0,1,0,0,0,2'd0,0,0,1)));
        end

        // T6: en low and swap_req high together in the frame's last cycle.
        start_run(1'b1, 2'd0);
        for (int k = 0; k <= 56; k++) begin
            if (k > 0) tick();
            if (k == 51) begin bus.en = 1'b0; bus.swap_req = 1'b1; end
            if (k == 52) bus.swap_req = 1'b0;
            #1;
            if (k == 50) check("t6_no_early_ack", 32'(bus.swap_ack), 32'd0);
            if (k == 51) check("t6_ack", 32'({bus.frame_done, bus.swap_ack, bus.buf_sel}), 32'b110);
            if (k == 52) check("t6_buf_toggled", 32'({bus.swap_ack, bus.buf_sel}), 32'b01);
            if (k == 53) check("t6_idle", 32'({bus.mclk, bus.oe_n, bus.latch}), 32'b010);
            if (k == 56) check("t6_buf_hold", 32'(bus.buf_sel), 32'd1);
        end

`ifdef SCAN_DIM_EN
        // T5: dim=1 halves each plane's lit time, dim=2 blanks plane 0 entirely.
        start_run(1'b1, 2'd1);
        for (int k = 0; k <= 51; k++) begin
            if (k > 0) tick();
            #1;
            if (k == 10) check("t5_d1_p0_on", 32'(bus.oe_n), 32'd0);
            if (k == 11) check("t5_d1_p0_off", 32'(bus.oe_n), 32'd1);
            if (k == 21) check("t5_d1_latch", 32'(bus.latch), 32'd1);
            if (k == 23) check("t5_d1_p1_on", 32'(bus.oe_n), 32'd0);
            if (k == 24) check("t5_d1_p1_off", 32'(bus.oe_n), 32'd1);
        end
        start_run(1'b1, 2'd2);
        for (int k = 0; k <= 52; k++) begin
            if (k > 0) tick();
            #1;
            if (k == 10 || k == 11) check($sformatf("t5_d2_p0_c%0d", k), 32'(bus.oe_n), 32'd1);
            if (k == 22) check("t5_d2_p1_on", 32'(bus.oe_n), 32'd0);
            if (k == 51) check("t5_d2_frame_len", 32'({bus.frame_done, bus.oe_n}), 32'b11);
            if (k == 52) check("t5_d2_restart", 32'(bus.frame_done), 32'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
